// File: rtl/mat_vec_acc.sv
// Vector-matrix product y = x^T M over GF(Q): one matrix row per handshake,
// PASTA_S parallel multiply-accumulate lanes, result registered on the last row.
module mat_vec_acc #(
   parameter int BITLEN  = 17,
   parameter int Q       = 65537,
   parameter int PASTA_S = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [BITLEN*PASTA_S-1:0] state_in,
   input  logic                      row_valid,
   input  logic [BITLEN*PASTA_S-1:0] row_in,
   output logic                      row_ready,
   output logic                      busy,
   output logic                      done,
   output logic [BITLEN*PASTA_S-1:0] vec_out
);

   // Handshake: a row transfers on a rising edge where row_valid and row_ready
   // are both high; row_ready is high exactly while accumulating, so row_valid
   // and row_in are don't-care in IDLE and no row is ever held back by the block.

   localparam int CW = (PASTA_S > 1) ? $clog2(PASTA_S) : 1;
   localparam int PW = 2 * BITLEN;
   localparam int DW = PW + 2;
   localparam logic signed [DW-1:0] Q_D = DW'(Q);
   localparam logic [BITLEN:0]      Q_S = (BITLEN + 1)'(Q);

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [BITLEN-1:0] x_q     [PASTA_S];
   logic [BITLEN-1:0] acc_q   [PASTA_S];
   logic [BITLEN-1:0] acc_nxt [PASTA_S];
   logic [BITLEN*PASTA_S-1:0] vec_nxt;
   logic [BITLEN-1:0] x_cur;
   logic              accept;
   logic              last;

   // p = hi*2^16 + lo and 2^16 == -1, so p == lo - hi; one +Q fixes a negative.
   function automatic logic [BITLEN-1:0] mod_mul(input logic [BITLEN-1:0] a,
                                                 input logic [BITLEN-1:0] b);
      logic [PW-1:0]        p;
      logic signed [DW-1:0] d;
      p = {{BITLEN{1'b0}}, a} * {{BITLEN{1'b0}}, b};
      d = $signed({{(DW-16){1'b0}}, p[15:0]}) - $signed({2'b00, {16{1'b0}}, p[PW-1:16]});
      if (d[DW-1]) d = d + Q_D;
      return d[BITLEN-1:0];
   endfunction

   function automatic logic [BITLEN-1:0] mod_add(input logic [BITLEN-1:0] a,
                                                 input logic [BITLEN-1:0] b);
      logic [BITLEN:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= Q_S) s = s - Q_S;
      return s[BITLEN-1:0];
   endfunction

   assign busy      = (state == ACCUM);
   assign row_ready = busy;
   assign accept    = busy && row_valid;
   assign last      = accept && (cnt == CW'(PASTA_S - 1));
   assign x_cur     = x_q[cnt];

   for (genvar j = 0; j < PASTA_S; j++) begin : g_lane
      assign acc_nxt[j] = mod_add(acc_q[j], mod_mul(x_cur, row_in[BITLEN*j +: BITLEN]));
      assign vec_nxt[BITLEN*j +: BITLEN] = acc_nxt[j];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCUM;
         ACCUM:   if (last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         done    <= 1'b0;
         vec_out <= '0;
         for (int k = 0; k < PASTA_S; k++) begin
            x_q[k]   <= '0;
            acc_q[k] <= '0;
         end
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         if (state == IDLE && start) begin
            cnt <= '0;
            for (int k = 0; k < PASTA_S; k++) begin
               x_q[k]   <= state_in[BITLEN*k +: BITLEN];
               acc_q[k] <= '0;
            end
         end else if (accept) begin
            // Counter wraps to 0 on the last row, matching the IDLE return.
            cnt <= cnt + CW'(1);
            for (int k = 0; k < PASTA_S; k++) acc_q[k] <= acc_nxt[k];
            if (last) begin
               vec_out <= vec_nxt;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mat_vec_acc.sv
// Directed bench for mat_vec_acc: arithmetic reference model checked every cycle,
// plus literal expectations for identity, wrap, bubble, busy-start and reset cases.
module tb_mat_vec_acc;

   localparam int BITLEN = 17;
   localparam int Q      = 65537;
   localparam int S      = 32;
   localparam int W      = BITLEN * S;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] state_in = '0;
   logic         row_valid = 1'b0;
   logic [W-1:0] row_in = '0;
   logic         row_ready;
   logic         busy;
   logic         done;
   logic [W-1:0] vec_out;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   mat_vec_acc #(.BITLEN(BITLEN), .Q(Q), .PASTA_S(S)) dut (
      .clk(clk), .rst(rst), .start(start), .state_in(state_in),
      .row_valid(row_valid), .row_in(row_in), .row_ready(row_ready),
      .busy(busy), .done(done), .vec_out(vec_out)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model: records x and the accepted rows, then does plain modular sums
   longint       m_x [S];
   longint       m_rows [S][S];
   int           m_cnt = 0;
   logic         m_busy = 1'b0;
   logic         exp_done = 1'b0;
   logic [W-1:0] exp_vec = '0;

   function automatic int el(input logic [W-1:0] v, input int k);
      return int'(v[k*BITLEN +: BITLEN]);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_busy   = 1'b0;
         exp_done = 1'b0;
         exp_vec  = '0;
      end else begin
         exp_done = 1'b0;
         if (!m_busy) begin
            if (start) begin
               for (int k = 0; k < S; k++) m_x[k] = longint'(el(state_in, k));
               m_cnt  = 0;
               m_busy = 1'b1;
            end
         end else if (row_valid) begin
            for (int j = 0; j < S; j++) m_rows[m_cnt][j] = longint'(el(row_in, j));
            m_cnt++;
            if (m_cnt == S) begin
               for (int j = 0; j < S; j++) begin
                  longint acc;
                  acc = 0;
                  for (int i = 0; i < S; i++) acc += m_x[i] * m_rows[i][j];
                  exp_vec[j*BITLEN +: BITLEN] = BITLEN'(acc % Q);
               end
               exp_done = 1'b1;
               m_busy   = 1'b0;
            end
         end
      end
   end

   // scoreboard
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      check("busy", W'(busy), W'(m_busy));
      check("row_ready", W'(row_ready), W'(m_busy));
      check("done", W'(done), W'(exp_done));
      check("vec_out", vec_out, exp_vec);
      if (done === 1'b1) done_cnt++;
   end

   // driver tasks
   task automatic drive_cycle(input logic st, input logic [W-1:0] sv,
                              input logic rv, input logic [W-1:0] rin);
      start     = st;
      state_in  = sv;
      row_valid = rv;
      row_in    = rin;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] unit_row(input int i);
      logic [W-1:0] r;
      r = '0;
      r[i*BITLEN +: BITLEN] = BITLEN'(1);
      return r;
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] r;
      for (int k = 0; k < S; k++) r[k*BITLEN +: BITLEN] = BITLEN'($urandom_range(Q - 1, 0));
      return r;
   endfunction

   function automatic logic [W-1:0] garbage();
      logic [W-1:0] r;
      for (int k = 0; k < S; k++) r[k*BITLEN +: BITLEN] = BITLEN'($urandom);
      return r;
   endfunction

   // rows 0..n-1 of mat; optional bubble before each row; optional start injected at row 5
   task automatic send_rows(input logic [W-1:0] mat [S], input int n, input bit bubbles,
                            input bit inject, input logic [W-1:0] x_alt);
      for (int i = 0; i < n; i++) begin
         if (bubbles) drive_cycle(1'b0, '0, 1'b0, garbage());
         if (inject && i == 5) drive_cycle(1'b1, x_alt, 1'b1, mat[i]);
         else drive_cycle(1'b0, '0, 1'b1, mat[i]);
      end
   endtask

   task automatic check_elems(input string name, input int base, input int step);
      for (int k = 0; k < S; k++)
         check(name, W'(el(vec_out, k)), W'(base + step * k));
   endtask

   logic [W-1:0] x_id, x_wrap, x_alt, x_rnd;
   logic [W-1:0] m_id [S];
   logic [W-1:0] m_wrap [S];
   logic [W-1:0] m_rnd [S];

   initial begin
      for (int k = 0; k < S; k++) begin
         x_id[k*BITLEN +: BITLEN]   = BITLEN'(k + 1);
         x_wrap[k*BITLEN +: BITLEN] = BITLEN'(65536);
         x_alt[k*BITLEN +: BITLEN]  = BITLEN'(1000 + 3 * k);
         m_id[k] = unit_row(k);
      end
      for (int k = 0; k < S; k++) m_wrap[k] = {S{x_wrap[BITLEN-1:0]}};
      for (int k = 0; k < S; k++) m_rnd[k] = rand_vec();
      x_rnd = rand_vec();

      // reset for two cycles
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("rst_vec_out", vec_out, '0);
      check("rst_done", W'(done), '0);
      check("rst_busy", W'(busy), '0);
      check("rst_row_ready", W'(row_ready), '0);
      rst = 1'b0;

      // identity, started on the first cycle after reset
      done_cnt = 0;
      drive_cycle(1'b1, x_id, 1'b0, '0);
      send_rows(m_id, S, 1'b0, 1'b0, '0);
      check("id_done_now", W'(done), W'(1));
      check_elems("id_elem", 1, 1);

      // wrap case, started in the done cycle
      drive_cycle(1'b1, x_wrap, 1'b0, '0);
      check("id_done_once", W'(done_cnt), W'(1));
      send_rows(m_wrap, S, 1'b0, 1'b0, '0);
      drive_cycle(1'b0, '0, 1'b0, '0);
      check_elems("wrap_elem", 32, 0);

      // bubbles every other cycle
      done_cnt = 0;
      drive_cycle(1'b1, x_id, 1'b0, '0);
      send_rows(m_id, S, 1'b1, 1'b0, '0);
      check("bub_done_now", W'(done), W'(1));
      drive_cycle(1'b0, '0, 1'b0, '0);
      drive_cycle(1'b0, '0, 1'b0, '0);
      check("bub_done_once", W'(done_cnt), W'(1));
      check_elems("bub_elem", 1, 1);

      // start while busy is ignored
      drive_cycle(1'b1, x_id, 1'b0, '0);
      send_rows(m_id, S, 1'b0, 1'b1, x_alt);
      drive_cycle(1'b0, '0, 1'b0, '0);
      check_elems("busy_start_elem", 1, 1);

      // reset after 10 rows, with start and row_valid also high
      done_cnt = 0;
      drive_cycle(1'b1, x_rnd, 1'b0, '0);
      send_rows(m_rnd, 10, 1'b0, 1'b0, '0);
      rst = 1'b1;
      drive_cycle(1'b1, x_alt, 1'b1, m_rnd[10]);
      rst = 1'b0;
      check("mid_rst_vec_out", vec_out, '0);
      check("mid_rst_busy", W'(busy), '0);
      check("mid_rst_done_cnt", W'(done_cnt), '0);
      drive_cycle(1'b1, x_rnd, 1'b0, '0);
      send_rows(m_rnd, S, 1'b0, 1'b0, '0);
      drive_cycle(1'b0, '0, 1'b0, '0);
      drive_cycle(1'b0, '0, 1'b0, '0);
      check("rnd_done_once", W'(done_cnt), W'(1));

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
